l1tol2_req_tx: RTL and testbench
================================

L1TOL2_REQ_TX -- requirements
Module: l1tol2_req_tx

Interface
REQ-001: Parameter DEPTH, default 4, request-queue entries; SHALL be a power of 2, minimum 2.
REQ-002: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003: reset  input  1  asynchronous, active-high reset.
REQ-004: enq_valid  input  1  L1 miss logic presents a request this cycle.
REQ-005: enq_retry  output  1  queue cannot accept; the request SHALL NOT be captured.
REQ-006: enq_dcid, enq_cmd, enq_pcsign, enq_laddr, enq_sptbr  input  L1_reqid_type/SC_cmd_type/SC_pcsign_type/SC_laddr_type/SC_sptbr_type  request fields.
REQ-007: l1tol2_req_valid  output  1  head request is offered to the L2 pipe.
REQ-008: l1tol2_req_retry  input  1  L2 pipe refuses the offered request this cycle.
REQ-009: l1tol2_req_dcid, _cmd, _pcsign, _laddr, _sptbr  output  same types as REQ-006  head request fields.
REQ-010: busy  output  1  queue holds at least one entry.

Function
REQ-011: Enqueue handshake SHALL fire when enq_valid && !enq_retry; fields SHALL be written at the tail.
REQ-012: Dequeue handshake SHALL fire when l1tol2_req_valid && !l1tol2_req_retry; the head SHALL advance.
REQ-013: enq_retry SHALL equal (count == DEPTH), derived from registered state only; a same-cycle dequeue SHALL NOT free a slot for a same-cycle enqueue.
REQ-014: l1tol2_req_valid SHALL equal (count != 0); there SHALL be no empty-queue bypass, so the minimum enqueue-to-valid latency is 1 cycle.
REQ-015: While l1tol2_req_valid is high and l1tol2_req_retry is high, all l1tol2_req_* fields SHALL remain stable.
REQ-016: Requests SHALL leave in strict enqueue order; there SHALL be no reordering or merging.
REQ-017: On simultaneous enqueue and dequeue with 0 < count < DEPTH, count SHALL be unchanged and both pointers SHALL advance.
REQ-018: Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-019: An enqueue attempted while full SHALL be dropped by this block; the sender holds the request until enq_retry deasserts.
REQ-020: l1tol2_req_* fields SHALL be don't-care when l1tol2_req_valid is low.

Reset
REQ-021: While reset is high: count, head pointer and tail pointer SHALL be 0; l1tol2_req_valid = 0; busy = 0; enq_retry = 0.
REQ-022: A reset asserted mid-operation SHALL discard all queued requests immediately, regardless of the clock; payload storage need not be reset.
REQ-023: In the first clock edge after reset deasserts, an enqueue SHALL be accepted.

Configuration
REQ-024: Macro L1TOL2_REQ_RETRY_STATS_EN, when defined, SHALL add output retry_cycles (16 bits), a saturating count of cycles with l1tol2_req_valid && l1tol2_req_retry. The count SHALL reset to 0 and hold at 16'hFFFF.
REQ-025: Without L1TOL2_REQ_RETRY_STATS_EN, the retry_cycles port and its counter SHALL NOT exist; all other behaviour SHALL be identical.

Structure
REQ-026: L1_reqid_type, SC_cmd_type, SC_pcsign_type, SC_laddr_type and SC_sptbr_type SHALL come from the shared package; the block SHALL NOT redefine them.
REQ-027: Storage SHALL be one sub-module, l1tol2_req_fifo_mem: a DEPTH-entry register array with 1 write port and 1 asynchronous read port, holding the packed request fields.
REQ-028: Pointer, count and handshake logic SHALL reside in l1tol2_req_tx.

Verification
REQ-029: Single request: reset, then enqueue laddr=0x1000 with retry=0. SHALL see l1tol2_req_valid=1 with laddr=0x1000 one cycle later, and valid=0 the following cycle.
REQ-030: Backpressure: hold l1tol2_req_retry=1 for 5 cycles with DEPTH=4 and enqueue 5 requests. enq_retry SHALL assert after the 4th, the head fields SHALL stay stable, and the 5th SHALL be accepted only after one dequeue.
REQ-031: Ordering and wrap: stream 10 requests (dcid 0..9) with random retry. They SHALL arrive at L2 in order 0..9, with pointers wrapping twice.
REQ-032: Full plus simultaneous events: at count=4, assert enq_valid and dequeue in the same cycle. enq_retry SHALL be 1, count SHALL become 3, and the new request SHALL be dropped.
REQ-033: Reset mid-operation: with count=3, pulse reset between clock edges. Valid, busy and count SHALL be 0 immediately, and no stale request SHALL appear afterwards.
REQ-034: Statistics (L1TOL2_REQ_RETRY_STATS_EN defined): 7 cycles of valid with retry SHALL give retry_cycles=7; forcing 70000 such cycles SHALL saturate it at 0xFFFF.

Source files
------------

// File: rtl/l1tol2_req_tx_pkg.sv
// Shared L1-to-L2 request types and helpers.
// Types are owned here and imported by the request queue and its storage.
package l1tol2_req_tx_pkg;

  typedef logic [3:0]  L1_reqid_type;
  typedef logic [11:0] SC_pcsign_type;
  typedef logic [48:0] SC_laddr_type;
  typedef logic [37:0] SC_sptbr_type;

  typedef enum logic [2:0] {
    SC_CMD_NOP   = 3'd0,
    SC_CMD_LD    = 3'd1,
    SC_CMD_ST    = 3'd2,
    SC_CMD_PREF  = 3'd3,
    SC_CMD_FLUSH = 3'd4
  } SC_cmd_type;

  // One queued request, packed so storage can treat it as a plain word.
  typedef struct packed {
    L1_reqid_type  dcid;
    SC_cmd_type    cmd;
    SC_pcsign_type pcsign;
    SC_laddr_type  laddr;
    SC_sptbr_type  sptbr;
  } l1tol2_req_t;

  localparam int unsigned RETRY_CNT_W = 16;

  // Saturating increment for the retry statistics counter.
  function automatic logic [RETRY_CNT_W-1:0] sat_inc_retry(input logic [RETRY_CNT_W-1:0] v);
    return (v == {RETRY_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/l1tol2_req_tx_fifo_mem.sv
// Request storage: DEPTH-entry register array, one write port and one
// asynchronous read port. Payload is never reset; validity is tracked by
// the pointer/count logic in the parent.
module l1tol2_req_fifo_mem
  import l1tol2_req_tx_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  l1tol2_req_t      wdata,
  input  logic [PTR_W-1:0] raddr,
  output l1tol2_req_t      rdata
);

  l1tol2_req_t mem [DEPTH];

  // Capture the incoming request at the tail slot.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/l1tol2_req_tx.sv
// L1-to-L2 request transmit queue.
// Buffers L1 miss requests and offers them in order to the L2 pipe with a
// valid/retry handshake. Full and valid are derived from registered state
// only, so there is no empty bypass and no same-cycle slot reuse.
// Optional feature: define L1TOL2_REQ_RETRY_STATS_EN to add retry_cycles,
// a saturating count of cycles the head was offered and refused.
module l1tol2_req_tx
  import l1tol2_req_tx_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enq_valid,
  output logic          enq_retry,
  input  L1_reqid_type  enq_dcid,
  input  SC_cmd_type    enq_cmd,
  input  SC_pcsign_type enq_pcsign,
  input  SC_laddr_type  enq_laddr,
  input  SC_sptbr_type  enq_sptbr,
  output logic          l1tol2_req_valid,
  input  logic          l1tol2_req_retry,
  output L1_reqid_type  l1tol2_req_dcid,
  output SC_cmd_type    l1tol2_req_cmd,
  output SC_pcsign_type l1tol2_req_pcsign,
  output SC_laddr_type  l1tol2_req_laddr,
  output SC_sptbr_type  l1tol2_req_sptbr,
  output logic          busy
`ifdef L1TOL2_REQ_RETRY_STATS_EN
  ,
  output logic [RETRY_CNT_W-1:0] retry_cycles
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count;
  logic             enq_fire;
  logic             deq_fire;
  l1tol2_req_t      wr_req;
  l1tol2_req_t      rd_req;

  assign enq_retry        = (count == FULL_CNT);
  assign l1tol2_req_valid = (count != '0);
  assign busy             = l1tol2_req_valid;
  assign enq_fire         = enq_valid && !enq_retry;
  assign deq_fire         = l1tol2_req_valid && !l1tol2_req_retry;

  assign wr_req = '{dcid:   enq_dcid,
                    cmd:    enq_cmd,
                    pcsign: enq_pcsign,
                    laddr:  enq_laddr,
                    sptbr:  enq_sptbr};

  l1tol2_req_fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (enq_fire),
    .waddr (tail_ptr),
    .wdata (wr_req),
    .raddr (head_ptr),
    .rdata (rd_req)
  );

  // Head fields come straight from storage; stable while retried since head_ptr holds.
  assign l1tol2_req_dcid   = rd_req.dcid;
  assign l1tol2_req_cmd    = rd_req.cmd;
  assign l1tol2_req_pcsign = rd_req.pcsign;
  assign l1tol2_req_laddr  = rd_req.laddr;
  assign l1tol2_req_sptbr  = rd_req.sptbr;

  // Pointer and occupancy tracking; reset empties the queue immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (enq_fire) begin
        tail_ptr <= tail_ptr + 1'b1;
      end
      if (deq_fire) begin
        head_ptr <= head_ptr + 1'b1;
      end
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef L1TOL2_REQ_RETRY_STATS_EN
  // Count cycles where the head is offered but refused, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retry_cycles <= '0;
    end else if (l1tol2_req_valid && l1tol2_req_retry) begin
      retry_cycles <= sat_inc_retry(retry_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_l1tol2_req_tx.sv
// Directed self-checking bench for l1tol2_req_tx (DEPTH = 4).
// Inputs are driven and outputs sampled on the falling edge.
// Statistics checks are compiled only with L1TOL2_REQ_RETRY_STATS_EN.
module tb_l1tol2_req_tx;
  import l1tol2_req_tx_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          enq_valid;
  logic          enq_retry;
  L1_reqid_type  enq_dcid;
  SC_cmd_type    enq_cmd;
  SC_pcsign_type enq_pcsign;
  SC_laddr_type  enq_laddr;
  SC_sptbr_type  enq_sptbr;
  logic          l1tol2_req_valid;
  logic          l1tol2_req_retry;
  L1_reqid_type  l1tol2_req_dcid;
  SC_cmd_type    l1tol2_req_cmd;
  SC_pcsign_type l1tol2_req_pcsign;
  SC_laddr_type  l1tol2_req_laddr;
  SC_sptbr_type  l1tol2_req_sptbr;
  logic          busy;
`ifdef L1TOL2_REQ_RETRY_STATS_EN
  logic [15:0]   retry_cycles;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  l1tol2_req_tx #(.DEPTH(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .enq_valid         (enq_valid),
    .enq_retry         (enq_retry),
    .enq_dcid          (enq_dcid),
    .enq_cmd           (enq_cmd),
    .enq_pcsign        (enq_pcsign),
    .enq_laddr         (enq_laddr),
    .enq_sptbr         (enq_sptbr),
    .l1tol2_req_valid  (l1tol2_req_valid),
    .l1tol2_req_retry  (l1tol2_req_retry),
    .l1tol2_req_dcid   (l1tol2_req_dcid),
    .l1tol2_req_cmd    (l1tol2_req_cmd),
    .l1tol2_req_pcsign (l1tol2_req_pcsign),
    .l1tol2_req_laddr  (l1tol2_req_laddr),
    .l1tol2_req_sptbr  (l1tol2_req_sptbr),
    .busy              (busy)
`ifdef L1TOL2_REQ_RETRY_STATS_EN
    ,
    .retry_cycles      (retry_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Request payload is a fixed function of its id; id 0 carries laddr 0x1000.
  function automatic SC_laddr_type laddr_of(input int id);
    return SC_laddr_type'(64'h1000 + (64'(id) << 8));
  endfunction
  function automatic SC_pcsign_type pcsign_of(input int id);
    return SC_pcsign_type'(12'h100 + id);
  endfunction
  function automatic SC_sptbr_type sptbr_of(input int id);
    return SC_sptbr_type'(38'h3000 + id);
  endfunction
  function automatic SC_cmd_type cmd_of(input int id);
    int b;
    b = id % 2;
    return (b == 1) ? SC_CMD_ST : SC_CMD_LD;
  endfunction

  task automatic drive_req(input int id);
    enq_dcid   = L1_reqid_type'(id);
    enq_cmd    = cmd_of(id);
    enq_pcsign = pcsign_of(id);
    enq_laddr  = laddr_of(id);
    enq_sptbr  = sptbr_of(id);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_head(input string tag, input int id);
    chk({tag, "_valid"},  l1tol2_req_valid,  1'b1);
    chk({tag, "_dcid"},   l1tol2_req_dcid,   L1_reqid_type'(id));
    chk({tag, "_laddr"},  l1tol2_req_laddr,  laddr_of(id));
    chk({tag, "_cmd"},    l1tol2_req_cmd,    cmd_of(id));
    chk({tag, "_pcsign"}, l1tol2_req_pcsign, pcsign_of(id));
    chk({tag, "_sptbr"},  l1tol2_req_sptbr,  sptbr_of(id));
  endtask

  // Dequeue everything with no backpressure, expecting exactly ids in order.
  task automatic drain(input string tag, input int ids[$]);
    enq_valid        = 1'b0;
    l1tol2_req_retry = 1'b0;
    foreach (ids[i]) begin
      check_head(tag, ids[i]);
      step();
    end
    chk({tag, "_empty_valid"}, l1tol2_req_valid, 1'b0);
    chk({tag, "_empty_busy"},  busy,             1'b0);
  endtask

  // Fill with ids while the L2 side refuses everything.
  task automatic fill(input int ids[$]);
    l1tol2_req_retry = 1'b1;
    foreach (ids[i]) begin
      drive_req(ids[i]);
      enq_valid = 1'b1;
      step();
    end
    enq_valid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int q[$];
    int sent;
    int got;
    int cyc;
    logic fire_e;
    logic fire_d;

    reset            = 1'b1;
    enq_valid        = 1'b0;
    l1tol2_req_retry = 1'b0;
    drive_req(0);

    // Reset state
    #2;
    chk("rst_valid", l1tol2_req_valid, 1'b0);
    chk("rst_busy",  busy,             1'b0);
    chk("rst_retry", enq_retry,        1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single request, enqueued on the first edge after reset
    drive_req(0);
    enq_valid = 1'b1;
    step();
    enq_valid = 1'b0;
    check_head("single", 0);
    chk("single_busy", busy, 1'b1);
    step();
    chk("single_after_valid", l1tol2_req_valid, 1'b0);
    chk("single_after_busy",  busy,             1'b0);

    // Backpressure: four accepted, fifth held until one dequeue
    l1tol2_req_retry = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("bp_enq_retry_lo", enq_retry, 1'b0);
      drive_req(i);
      enq_valid = 1'b1;
      step();
    end
    drive_req(5);
    enq_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_enq_retry_hi", enq_retry, 1'b1);
      check_head("bp_stable", 1);
      step();
    end
    l1tol2_req_retry = 1'b0;
    chk("bp_full_at_deq", enq_retry, 1'b1);
    step();
    l1tol2_req_retry = 1'b1;
    chk("bp_slot_freed", enq_retry, 1'b0);
    check_head("bp_head2", 2);
    step();
    enq_valid = 1'b0;
    chk("bp_full_again", enq_retry, 1'b1);
    drain("bp_drain", '{2, 3, 4, 5});

    // Full with simultaneous enqueue and dequeue: enqueue is dropped
    fill('{6, 7, 8, 9});
    chk("full_retry", enq_retry, 1'b1);
    drive_req(15);
    enq_valid        = 1'b1;
    l1tol2_req_retry = 1'b0;
    step();
    enq_valid = 1'b0;
    chk("full_after_retry", enq_retry, 1'b0);
    drain("full_drain", '{7, 8, 9});

    // Ordered stream of ten with random backpressure; pointers wrap twice
    sent = 0;
    got  = 0;
    cyc  = 0;
    q    = {};
    while (got < 10 && cyc < 300) begin
      chk("st_enq_retry", enq_retry, 1'((q.size() == 4)));
      chk("st_valid", l1tol2_req_valid, 1'((q.size() != 0)));
      if (q.size() != 0) begin
        chk("st_dcid", l1tol2_req_dcid, L1_reqid_type'(q[0]));
        chk("st_laddr", l1tol2_req_laddr, laddr_of(q[0]));
      end
      enq_valid = (sent < 10);
      if (sent < 10) drive_req(sent);
      l1tol2_req_retry = ($urandom_range(0, 2) == 0);
      fire_e = enq_valid && (q.size() != 4);
      fire_d = (q.size() != 0) && !l1tol2_req_retry;
      step();
      if (fire_d) begin
        void'(q.pop_front());
        got++;
      end
      if (fire_e) begin
        q.push_back(sent);
        sent++;
      end
      cyc++;
    end
    chk("st_all_delivered", 64'(got), 64'd10);
    enq_valid        = 1'b0;
    l1tol2_req_retry = 1'b0;
    step();
    chk("st_empty", l1tol2_req_valid, 1'b0);

    // Asynchronous reset mid-operation with three queued
    fill('{1, 2, 3});
    chk("mid_pre_valid", l1tol2_req_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", l1tol2_req_valid, 1'b0);
    chk("mid_rst_busy",  busy,             1'b0);
    chk("mid_rst_retry", enq_retry,        1'b0);
    #1 reset = 1'b0;
    @(negedge clk);
    l1tol2_req_retry = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("mid_no_stale", l1tol2_req_valid, 1'b0);
      step();
    end
    drive_req(12);
    enq_valid = 1'b1;
    step();
    enq_valid = 1'b0;
    check_head("mid_new", 12);
    step();
    chk("mid_new_gone", l1tol2_req_valid, 1'b0);

`ifdef L1TOL2_REQ_RETRY_STATS_EN
    // Retry statistics: exact count, then saturation
    #2 reset = 1'b1;
    #1;
    chk("stat_rst", retry_cycles, 16'd0);
    #1 reset = 1'b0;
    @(negedge clk);
    fill('{3});
    chk("stat_zero", retry_cycles, 16'd0);
    repeat (7) step();
    chk("stat_seven", retry_cycles, 16'd7);
    repeat (70000) step();
    chk("stat_sat", retry_cycles, 16'hFFFF);
    drain("stat_drain", '{3});
    chk("stat_hold", retry_cycles, 16'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
